writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 152 +++++++++++++++
 tb/tb_writeback_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : writeback_queue
// Purpose  : Register-file writeback FIFO with load-data extension, zero-reg
//            discard and youngest-entry forwarding lookup.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_queue #(
    parameter int DATA_WIDTH        = 16,
    parameter int ADDR_WIDTH        = 4,
    parameter int DEPTH             = 4,
    parameter int ZERO_REG_WRITABLE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] result_wb,
    input  logic [DATA_WIDTH-1:0] load_data_wb,
    input  logic                  load_enable_wb,
    input  logic [1:0]            load_size_wb,
    input  logic                  write_enable_wb,
    input  logic [ADDR_WIDTH-1:0] reg_addr_wb,
    input  logic                  rf_ready,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [ADDR_WIDTH-1:0] reg_addr_out,
    output logic                  write_enable_out,
    input  logic [ADDR_WIDTH-1:0] fwd_query_addr,
    output logic                  fwd_hit,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic [ADDR_WIDTH:0]   queue_count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = ADDR_WIDTH + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (DEPTH > ((1 << c_CNT_W) - 1)) || (DATA_WIDTH < 8)) begin : g_bad_params
        $error("writeback_queue: DEPTH must be a power of two >= 2 that fits queue_count, DATA_WIDTH >= 8");
    end

    // Storage and control state
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [c_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_CNT_W-1:0]    count_q, count_d;

    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_addr_ok;
    logic [DATA_WIDTH-1:0] w_sext;
    logic [DATA_WIDTH-1:0] w_zext;
    logic [DATA_WIDTH-1:0] w_push_data;

    if (DATA_WIDTH > 8) begin : g_ext_wide
        assign w_sext = {{(DATA_WIDTH-8){load_data_wb[7]}}, load_data_wb[7:0]};
        assign w_zext = {{(DATA_WIDTH-8){1'b0}}, load_data_wb[7:0]};
    end else begin : g_ext_narrow
        assign w_sext = load_data_wb;
        assign w_zext = load_data_wb;
    end

    always_comb begin
        w_push_data = result_wb;
        if (load_enable_wb) begin
            case (load_size_wb)
                2'b01:   w_push_data = w_sext;
                2'b10:   w_push_data = w_zext;
                default: w_push_data = load_data_wb;
            endcase
        end
    end

    // Readiness depends only on registered occupancy, never on a same-cycle pop
    assign in_ready  = (count_q < c_DEPTH);
    assign w_accept  = in_valid && in_ready;
    assign w_addr_ok = (ZERO_REG_WRITABLE != 0) || (reg_addr_wb != '0);
    assign w_push    = w_accept && write_enable_wb && w_addr_ok;
    assign w_pop     = (count_q != '0) && rf_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                data_q[wr_ptr_q] <= w_push_data;
                addr_q[wr_ptr_q] <= reg_addr_wb;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Write port: head entry, forced to zero when empty
    always_comb begin
        write_enable_out = (count_q != '0);
        write_data       = '0;
        reg_addr_out     = '0;
        if (count_q != '0) begin
            write_data   = data_q[rd_ptr_q];
            reg_addr_out = addr_q[rd_ptr_q];
        end
    end

    // Walk oldest to youngest so the youngest matching entry overwrites earlier hits
    always_comb begin
        logic [c_PTR_W-1:0] v_idx;
        v_idx    = rd_ptr_q;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = rd_ptr_q + c_PTR_W'(i);
            if ((c_CNT_W'(i) < count_q) && (addr_q[v_idx] == fwd_query_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[v_idx];
            end
        end
    end

    assign queue_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_queue
// Purpose  : Self-checking bench: directed vector table, corner sequences and
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_queue;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] result_wb;
    logic [DW-1:0] load_data_wb;
    logic          load_enable_wb;
    logic [1:0]    load_size_wb;
    logic          write_enable_wb;
    logic [AW-1:0] reg_addr_wb;
    logic          rf_ready;
    logic [DW-1:0] write_data;
    logic [AW-1:0] reg_addr_out;
    logic          write_enable_out;
    logic [AW-1:0] fwd_query_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [AW:0]   queue_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    writeback_queue #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .ZERO_REG_WRITABLE(0)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .result_wb(result_wb), .load_data_wb(load_data_wb),
        .load_enable_wb(load_enable_wb), .load_size_wb(load_size_wb),
        .write_enable_wb(write_enable_wb), .reg_addr_wb(reg_addr_wb),
        .rf_ready(rf_ready),
        .write_data(write_data), .reg_addr_out(reg_addr_out),
        .write_enable_out(write_enable_out),
        .fwd_query_addr(fwd_query_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .queue_count(queue_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_valid = 1'b1; write_enable_wb = 1'b1; load_enable_wb = 1'b0;
        reg_addr_wb = a; result_wb = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Reference value for a request, from the extension rules in plain arithmetic
    function automatic logic [DW-1:0] ref_data(input logic le, input logic [1:0] ls,
                                               input logic [DW-1:0] res, input logic [DW-1:0] ld);
        int b;
        b = int'(ld) % 256;
        if (!le) return res;
        case (ls)
            2'd1:    return (b >= 128) ? DW'(b - 256) : DW'(b);
            2'd2:    return DW'(b);
            default: return ld;
        endcase
    endfunction

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic          le;
        logic [1:0]    ls;
        logic [DW-1:0] res;
        logic [DW-1:0] ld;
        logic          exp_we;
        logic [DW-1:0] exp_data;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t vecs[9];

    // Reference model: entries packed as {addr, data}, oldest at index 0
    logic [AW+DW-1:0] model_q[$];

    initial begin
        vecs[0] = '{1'b1, 4'd3, 1'b0, 2'd0, 16'h00AA, 16'h0000, 1'b1, 16'h00AA, 4'd3};
        vecs[1] = '{1'b0, 4'd5, 1'b0, 2'd0, 16'h1234, 16'h0000, 1'b0, 16'h0000, 4'd0};
        vecs[2] = '{1'b1, 4'd0, 1'b0, 2'd0, 16'h5555, 16'h0000, 1'b0, 16'h0000, 4'd0};
        vecs[3] = '{1'b1, 4'd2, 1'b1, 2'd1, 16'hBEEF, 16'h1280, 1'b1, 16'hFF80, 4'd2};
        vecs[4] = '{1'b1, 4'd2, 1'b1, 2'd2, 16'hBEEF, 16'h1280, 1'b1, 16'h0080, 4'd2};
        vecs[5] = '{1'b1, 4'd2, 1'b1, 2'd0, 16'hBEEF, 16'h1280, 1'b1, 16'h1280, 4'd2};
        vecs[6] = '{1'b1, 4'd9, 1'b1, 2'd3, 16'hBEEF, 16'h1280, 1'b1, 16'h1280, 4'd9};
        vecs[7] = '{1'b1, 4'd15, 1'b1, 2'd1, 16'h0000, 16'h347F, 1'b1, 16'h007F, 4'd15};
        vecs[8] = '{1'b1, 4'd1, 1'b0, 2'd1, 16'h8001, 16'h12FF, 1'b1, 16'h8001, 4'd1};

        rst = 1'b1; in_valid = 1'b0; result_wb = '0; load_data_wb = '0;
        load_enable_wb = 1'b0; load_size_wb = 2'd0; write_enable_wb = 1'b0;
        reg_addr_wb = '0; rf_ready = 1'b1; fwd_query_addr = '0;

        #12;
        chk("rst_we_out", 32'(write_enable_out), 32'd0);
        chk("rst_count", 32'(queue_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_data", 32'(write_data), 32'd0);
        chk("post_rst_addr", 32'(reg_addr_out), 32'd0);
        chk("post_rst_fwd_hit", 32'(fwd_hit), 32'd0);
        chk("post_rst_fwd_data", 32'(fwd_data), 32'd0);

        // Directed vector table, each request into an empty queue with rf_ready=1
        for (int v = 0; v < 9; v++) begin
            in_valid = 1'b1; write_enable_wb = vecs[v].we; reg_addr_wb = vecs[v].addr;
            load_enable_wb = vecs[v].le; load_size_wb = vecs[v].ls;
            result_wb = vecs[v].res; load_data_wb = vecs[v].ld; rf_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_we_out", v), 32'(write_enable_out), 32'(vecs[v].exp_we));
            chk($sformatf("vec%0d_data", v), 32'(write_data), 32'(vecs[v].exp_data));
            chk($sformatf("vec%0d_addr", v), 32'(reg_addr_out), 32'(vecs[v].exp_addr));
            chk($sformatf("vec%0d_count", v), 32'(queue_count), vecs[v].exp_we ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("vec%0d_drained", v), 32'(write_enable_out), 32'd0);
        end
        load_enable_wb = 1'b0; load_size_wb = 2'd0;

        // Fill to DEPTH with the write port stalled, then retire in order
        rf_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(AW'(i), DW'(i * 'h11));
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(queue_count), 32'd4);
        push(4'd9, 16'h0099);
        chk("full_no_accept", 32'(queue_count), 32'd4);
        chk("stall_head_addr", 32'(reg_addr_out), 32'd1);
        chk("stall_head_data", 32'(write_data), 32'h11);
        rf_ready = 1'b1;
        in_valid = 1'b1; write_enable_wb = 1'b1; reg_addr_wb = 4'd9; result_wb = 16'h0099;
        chk("full_pop_in_ready", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("full_pop_count", 32'(queue_count), 32'd3);
        for (int i = 2; i <= 4; i++) begin
            chk($sformatf("retire%0d_addr", i), 32'(reg_addr_out), 32'(i));
            chk($sformatf("retire%0d_data", i), 32'(write_data), 32'(i * 'h11));
            tick();
        end
        chk("retire_empty", 32'(queue_count), 32'd0);

        // Forwarding picks the youngest of two same-address entries
        rf_ready = 1'b0;
        push(4'd6, 16'h0010);
        push(4'd6, 16'h0020);
        fwd_query_addr = 4'd6; #1;
        chk("fwd6_hit", 32'(fwd_hit), 32'd1);
        chk("fwd6_data", 32'(fwd_data), 32'h0020);
        fwd_query_addr = 4'd7; #1;
        chk("fwd7_hit", 32'(fwd_hit), 32'd0);
        chk("fwd7_data", 32'(fwd_data), 32'd0);

        // Asynchronous reset mid-cycle with three pending entries
        push(4'd2, 16'h0033);
        chk("pre_rst_count", 32'(queue_count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_we_out", 32'(write_enable_out), 32'd0);
        chk("async_rst_count", 32'(queue_count), 32'd0);
        fwd_query_addr = 4'd6; #1;
        chk("async_rst_fwd", 32'(fwd_hit), 32'd0);
        in_valid = 1'b1; write_enable_wb = 1'b1; reg_addr_wb = 4'd5; result_wb = 16'h0055;
        tick(); tick();
        in_valid = 1'b0;
        chk("rst_ignores_valid", 32'(queue_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_release_count", 32'(queue_count), 32'd0);
        chk("rst_release_ready", 32'(in_ready), 32'd1);

        // Randomized traffic against the reference model
        rf_ready = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            logic             acc, pop, hit;
            logic [DW-1:0]    exp_fwd;
            in_valid        = ($urandom_range(0, 9) < 7);
            rf_ready        = ($urandom_range(0, 9) < 5);
            write_enable_wb = ($urandom_range(0, 9) < 9);
            reg_addr_wb     = AW'($urandom_range(0, 7));
            load_enable_wb  = $urandom_range(0, 1) == 1;
            load_size_wb    = 2'($urandom_range(0, 3));
            result_wb       = DW'($urandom);
            load_data_wb    = DW'($urandom);
            fwd_query_addr  = AW'($urandom_range(0, 7));
            #3;
            chk("rnd_count", 32'(queue_count), 32'(model_q.size()));
            chk("rnd_in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
            chk("rnd_we_out", 32'(write_enable_out), 32'(model_q.size() != 0));
            chk("rnd_data", 32'(write_data), (model_q.size() != 0) ? 32'(model_q[0][DW-1:0]) : 32'd0);
            chk("rnd_addr", 32'(reg_addr_out), (model_q.size() != 0) ? 32'(model_q[0][AW+DW-1:DW]) : 32'd0);
            hit = 1'b0; exp_fwd = '0;
            for (int k = model_q.size() - 1; k >= 0 && !hit; k--) begin
                if (model_q[k][AW+DW-1:DW] == fwd_query_addr) begin
                    hit = 1'b1; exp_fwd = model_q[k][DW-1:0];
                end
            end
            chk("rnd_fwd_hit", 32'(fwd_hit), 32'(hit));
            chk("rnd_fwd_data", 32'(fwd_data), 32'(exp_fwd));
            acc = in_valid && (model_q.size() < DEPTH) && write_enable_wb && (reg_addr_wb != 0);
            pop = (model_q.size() != 0) && rf_ready;
            if (pop) void'(model_q.pop_front());
            if (acc) model_q.push_back({reg_addr_wb,
                ref_data(load_enable_wb, load_size_wb, result_wb, load_data_wb)});
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1);
    end

endmodule
`default_nettype wire
